// File: rtl/feeder_pkg.sv
// Shared widths and sequencer state encoding for the node_feeder slice.
package feeder_pkg;

    localparam int CHUNK_W    = 128;
    localparam int PIX_W      = 8;
    localparam int NODE_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        WAIT,
        CAPTURE,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/feeder_addr_gen.sv
// Chunk counter, node index and weight base for node_feeder; the weight
// address is built by accumulating N_CHUNKS per node instead of multiplying.
module feeder_addr_gen
    import feeder_pkg::*;
#(
    parameter int N_CHUNKS = 49,
    parameter int IMG_AW   = 6,
    parameter int W_AW     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_chunk_step,
    input  logic                  i_node_step,
    input  logic                  i_pass_clr,
    output logic [NODE_IDX_W-1:0] o_node_idx,
    output logic                  o_first_chunk,
    output logic                  o_last_chunk,
    output logic [IMG_AW-1:0]     o_img_addr,
    output logic [W_AW-1:0]       o_w_addr
);

    logic [IMG_AW-1:0]     r_chunk;
    logic [NODE_IDX_W-1:0] r_node_idx;
    logic [W_AW-1:0]       r_w_base;
    logic [IMG_AW-1:0]     w_offset;

    assign o_first_chunk = (r_chunk == '0);
    assign o_last_chunk  = (r_chunk == IMG_AW'(N_CHUNKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chunk    <= '0;
            r_node_idx <= '0;
            r_w_base   <= '0;
        end else if (i_pass_clr) begin
            r_chunk    <= '0;
            r_node_idx <= '0;
            r_w_base   <= '0;
        end else begin
            if (i_chunk_step) begin
                r_chunk <= o_last_chunk ? '0 : r_chunk + 1'b1;
            end
            if (i_node_step) begin
                r_node_idx <= r_node_idx + 1'b1;
                r_w_base   <= r_w_base + W_AW'(N_CHUNKS);
            end
        end
    end

    // While streaming, present the next chunk so sync-read data lines up;
    // on the last chunk the address holds so it never leaves the node's range.
    assign w_offset   = (i_chunk_step && !o_last_chunk) ? r_chunk + 1'b1 : r_chunk;
    assign o_img_addr = w_offset;
    assign o_w_addr   = r_w_base + W_AW'(w_offset);
    assign o_node_idx = r_node_idx;

endmodule

// File: rtl/node_feeder.sv
// Sequences image/weight chunks into node_func for each neuron and captures
// its output. Define NODE_ARGMAX_EN to add the pred_digit/pred_valid argmax.
module node_feeder
    import feeder_pkg::*;
#(
    parameter int N_NODES  = 10,
    parameter int N_CHUNKS = 49,
    parameter int NODE_LAT = 2,
    parameter int IMG_AW   = 6,
    parameter int W_AW     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IMG_AW-1:0]     img_addr,
    input  logic [CHUNK_W-1:0]    img_data,
    output logic [W_AW-1:0]       w_addr,
    input  logic [CHUNK_W-1:0]    w_data,
    output logic [NODE_IDX_W-1:0] bias_addr,
    input  logic [PIX_W-1:0]      bias_data,
    output logic [CHUNK_W-1:0]    pixels,
    output logic [CHUNK_W-1:0]    weights,
    output logic [PIX_W-1:0]      b,
    output logic                  node_clr,
    output logic                  mac_valid,
    input  logic [PIX_W-1:0]      node_out,
    output logic [PIX_W-1:0]      result,
    output logic [NODE_IDX_W-1:0] result_idx,
    output logic                  result_valid,
`ifdef NODE_ARGMAX_EN
    output logic [NODE_IDX_W-1:0] pred_digit,
    output logic                  pred_valid,
`endif
    output feeder_state_t         dbg_state
);

    localparam int LAT_W = (NODE_LAT > 1) ? $clog2(NODE_LAT) : 1;

    feeder_state_t         r_state;
    feeder_state_t         w_next;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [PIX_W-1:0]      r_b;
    logic [PIX_W-1:0]      r_result;
    logic [NODE_IDX_W-1:0] r_result_idx;
    logic                  r_result_valid;
    logic [NODE_IDX_W-1:0] w_node_idx;
    logic                  w_first_chunk;
    logic                  w_last_chunk;
    logic                  w_last_node;
    logic                  w_lat_last;

    assign w_last_node = (w_node_idx == NODE_IDX_W'(N_NODES - 1));
    assign w_lat_last  = (r_lat_cnt == LAT_W'(NODE_LAT - 1));

    feeder_addr_gen #(
        .N_CHUNKS(N_CHUNKS),
        .IMG_AW  (IMG_AW),
        .W_AW    (W_AW)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_chunk_step (r_state == STREAM),
        .i_node_step  ((r_state == CAPTURE) && !w_last_node),
        .i_pass_clr   (r_state == DONE),
        .o_node_idx   (w_node_idx),
        .o_first_chunk(w_first_chunk),
        .o_last_chunk (w_last_chunk),
        .o_img_addr   (img_addr),
        .o_w_addr     (w_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLR;
            CLR:     w_next = STREAM;
            STREAM:  if (w_last_chunk) w_next = WAIT;
            WAIT:    if (w_lat_last) w_next = CAPTURE;
            CAPTURE: w_next = w_last_node ? DONE : CLR;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        node_clr  = 1'b0;
        mac_valid = 1'b0;
        case (r_state)
            CLR:     begin busy = 1'b1; node_clr = 1'b1; end
            STREAM:  begin busy = 1'b1; mac_valid = 1'b1; end
            WAIT:    busy = 1'b1;
            CAPTURE: busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt      <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_result_idx   <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_lat_cnt      <= (r_state == WAIT && !w_lat_last) ? r_lat_cnt + 1'b1 : '0;
            r_result_valid <= (r_state == CAPTURE);
            if (r_state == STREAM && w_first_chunk) begin
                r_b <= bias_data;
            end
            if (r_state == CAPTURE) begin
                r_result     <= node_out;
                r_result_idx <= w_node_idx;
            end
        end
    end

    // Idle-time zeros keep a free-running accumulator from picking up stale data.
    assign pixels       = mac_valid ? img_data : '0;
    assign weights      = mac_valid ? w_data : '0;
    assign b            = r_b;
    assign bias_addr    = w_node_idx;
    assign result       = r_result;
    assign result_idx   = r_result_idx;
    assign result_valid = r_result_valid;
    assign dbg_state    = r_state;

`ifdef NODE_ARGMAX_EN
    logic [PIX_W-1:0]      r_max;
    logic [NODE_IDX_W-1:0] r_pred;

    // Strict greater-than keeps the lowest index on ties; node 0 always seeds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max  <= '0;
            r_pred <= '0;
        end else if (r_state == IDLE && start) begin
            r_max  <= '0;
            r_pred <= '0;
        end else if (r_state == CAPTURE && (w_node_idx == '0 || node_out > r_max)) begin
            r_max  <= node_out;
            r_pred <= w_node_idx;
        end
    end

    assign pred_digit = r_pred;
    assign pred_valid = done;
`endif

endmodule

// File: tb/tb_node_feeder.sv
// Randomized bench for node_feeder: memories hold random data and each pass
// is checked cycle by cycle against a schedule computed from the pass timing.
module tb_node_feeder;
    import feeder_pkg::*;

    localparam int N_NODES  = 10;
    localparam int N_CHUNKS = 49;
    localparam int NODE_LAT = 2;
    localparam int PER_NODE = 1 + N_CHUNKS + NODE_LAT + 1;
    localparam int PASS_LEN = N_NODES * PER_NODE + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, node_clr, mac_valid, result_valid;
    logic [5:0]   img_addr;
    logic [8:0]   w_addr;
    logic [3:0]   bias_addr, result_idx;
    logic [127:0] img_data, w_data, pixels, weights;
    logic [7:0]   bias_data, b, result;
    logic [7:0]   node_out = 8'd0;
    logic [2:0]   dbg_state;
`ifdef NODE_ARGMAX_EN
    logic [3:0]   pred_digit;
    logic         pred_valid;
`endif

    logic [127:0] img_mem [N_CHUNKS];
    logic [127:0] w_mem [N_NODES*N_CHUNKS];
    logic [7:0]   bias_mem [N_NODES];
    logic [7:0]   node_tbl [N_NODES];
    bit           mask_mode = 1'b0;

    logic [7:0]   exp_q[$];
    logic [3:0]   exp_idx_q[$];
    int           exp_pred;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    node_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .img_addr    (img_addr),
        .img_data    (img_data),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .bias_addr   (bias_addr),
        .bias_data   (bias_data),
        .pixels      (pixels),
        .weights     (weights),
        .b           (b),
        .node_clr    (node_clr),
        .mac_valid   (mac_valid),
        .node_out    (node_out),
        .result      (result),
        .result_idx  (result_idx),
        .result_valid(result_valid),
`ifdef NODE_ARGMAX_EN
        .pred_digit  (pred_digit),
        .pred_valid  (pred_valid),
`endif
        .dbg_state   (dbg_state)
    );

    // Synchronous-read memory models, one cycle of latency.
    always @(posedge clk) begin
        img_data  <= mask_mode ? {128{1'b1}} : img_mem[img_addr];
        w_data    <= w_mem[w_addr];
        bias_data <= bias_mem[bias_addr];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_node_clr", node_clr, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_pixels", pixels, 0);
        check("rst_weights", weights, 0);
        check("rst_b", b, 0);
        check("rst_result", result, 0);
        check("rst_result_idx", result_idx, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_bias_addr", bias_addr, 0);
    endtask

    task automatic prep_pass();
        exp_q.delete();
        exp_idx_q.delete();
        exp_pred = 0;
        for (int i = 0; i < N_NODES; i++) begin
            exp_q.push_back(node_tbl[i]);
            exp_idx_q.push_back(4'(i));
            if (node_tbl[i] > node_tbl[exp_pred]) exp_pred = i;
        end
    endtask

    // Entered at the falling edge of the first cycle after start was taken.
    // abort_at > 0 pulls reset during that cycle and returns.
    task automatic pass_checks(input int abort_at, input bit drop_start);
        for (int c = 1; c <= PASS_LEN; c++) begin
            int node, ph, k;
            bit in_done, in_clr, in_str, in_hold, rv;
            logic [7:0] e_res;
            logic [3:0] e_idx;
            in_done = (c == PASS_LEN);
            node    = in_done ? N_NODES - 1 : (c - 1) / PER_NODE;
            ph      = (c - 1) % PER_NODE;
            k       = ph - 1;
            in_clr  = !in_done && ph == 0;
            in_str  = !in_done && ph >= 1 && ph <= N_CHUNKS;
            in_hold = !in_done && ph > N_CHUNKS;
            rv      = (c >= 2) && ((c - 2) % PER_NODE == PER_NODE - 1);
            node_out = node_tbl[node];

            check("busy", busy, !in_done);
            check("done", done, in_done);
            check("node_clr", node_clr, in_clr);
            check("mac_valid", mac_valid, in_str);
            check("result_valid", result_valid, rv);
            if (result_valid) begin
                check("result_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_res = exp_q.pop_front();
                    e_idx = exp_idx_q.pop_front();
                    check("result", result, e_res);
                    check("result_idx", result_idx, e_idx);
                end
            end
            if (in_clr) begin
                check("clr_img_addr", img_addr, 0);
                check("clr_w_addr", w_addr, node * N_CHUNKS);
                check("clr_bias_addr", bias_addr, node);
            end
            if (in_str) begin
                check("pixels", pixels, mask_mode ? {128{1'b1}} : img_mem[k]);
                check("weights", weights, w_mem[node*N_CHUNKS + k]);
                if (k < N_CHUNKS - 1) begin
                    check("str_img_addr", img_addr, k + 1);
                    check("str_w_addr", w_addr, node * N_CHUNKS + k + 1);
                end
                if (k >= 1) check("b", b, bias_mem[node]);
            end else begin
                check("pixels_masked", pixels, 0);
                check("weights_masked", weights, 0);
            end
            if (in_hold) check("b_hold", b, bias_mem[node]);
`ifdef NODE_ARGMAX_EN
            check("pred_valid", pred_valid, in_done);
            if (in_done) check("pred_digit", pred_digit, exp_pred);
            if (c == 1) check("pred_cleared", pred_digit, 0);
`endif
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_all_zero();
                return;
            end
            @(negedge clk);
        end
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_node_clr", node_clr, 0);
        check("idle_result_valid", result_valid, 0);
        check("all_results_seen", exp_q.size(), 0);
        if (drop_start) start = 1'b0;
    endtask

    task automatic run_pass();
        prep_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pass_checks(0, 1'b0);
    endtask

    task automatic rand_tbl();
        for (int i = 0; i < N_NODES; i++) node_tbl[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        for (int i = 0; i < N_CHUNKS; i++)
            img_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < N_NODES*N_CHUNKS; i++)
            w_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < N_NODES; i++) begin
            bias_mem[i] = 8'($urandom_range(1, 255));
            node_tbl[i] = 8'(i * 7);
        end

        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero();
        check("rst_dbg_state", dbg_state, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reference pass: node_out = node_idx*7.
        run_pass();

        // Constant all-ones image: masking must zero pixels outside STREAM.
        mask_mode = 1'b1;
        rand_tbl();
        run_pass();
        mask_mode = 1'b0;

        // Reset at node 3, chunk 20, then a clean pass.
        rand_tbl();
        prep_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pass_checks(3 * PER_NODE + 1 + 20 + 1, 1'b0);
        exp_q.delete();
        exp_idx_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            check("post_abort_done", done, 0);
            check("post_abort_busy", busy, 0);
            check("post_abort_rv", result_valid, 0);
            @(negedge clk);
        end
        rand_tbl();
        run_pass();

        // Start held high: back-to-back passes, each beginning right after IDLE.
        rand_tbl();
        prep_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        pass_checks(0, 1'b0);
        rand_tbl();
        prep_pass();
        @(negedge clk);
        pass_checks(0, 1'b1);

`ifdef NODE_ARGMAX_EN
        node_tbl = '{8'd10, 8'd200, 8'd50, 8'd200, 8'd7, 8'd0, 8'd3, 8'd199, 8'd200, 8'd1};
        run_pass();
        for (int i = 0; i < N_NODES; i++) node_tbl[i] = 8'd77;
        run_pass();
        rand_tbl();
        run_pass();
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
